uart_rx_fifo: RTL and testbench

// - Receive buffer between each uart core's deserialiser and its rdr register in uart_regs.
// - Stores received characters plus per-character error flags.
// - Presents the oldest entry as a 32-bit rdr word to the PPC EBI read path.
// - Raises receive-trigger, timeout and overrun status bits for the sr register and interrupt logic.

---
 rtl/uart_rx_fifo_pkg.sv | 68 ++++++
 rtl/uart_fifo_mem.sv | 38 +++
 rtl/uart_rx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the UART receive FIFO, the UART core and uart_regs:
//   - rdr word bit-field offsets
//   - trigger-level encodings of the cr trig_lvl field
//   - error-flag bit order {break, framing, parity}
//   - helpers that decode the trigger level and pack the rdr word
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

   // rdr word layout: {16'h0, valid, cnt[3:0], err[2:0], data[7:0]}
   localparam int DATA_LSB    = 0;
   localparam int ERR_LSB     = 8;
   localparam int CNT_LSB     = 11;
   localparam int VALID_BIT   = 15;
   localparam int DATA_W      = 8;
   localparam int CNT_FIELD_W = 4;

   // cr trig_lvl encodings
   typedef enum logic [1:0] {
      TRIG_1         = 2'b00,
      TRIG_4         = 2'b01,
      TRIG_8         = 2'b10,
      TRIG_NEAR_FULL = 2'b11
   } trig_lvl_e;

   // Error flags in the order the uart core reports them (MSB first).
   typedef struct packed {
      logic brk;
      logic framing;
      logic parity;
   } rx_err_t;

   // One FIFO entry: error flags above the character.
   typedef struct packed {
      rx_err_t           err;
      logic [DATA_W-1:0] data;
   } rx_entry_t;

   localparam int ENTRY_W = $bits(rx_entry_t);

   // Number of held entries at which trig_o asserts.
   function automatic logic [6:0] trig_level(input trig_lvl_e lvl, input logic [6:0] depth);
      logic [6:0] level;
      case (lvl)
         TRIG_1:         level = 7'd1;
         TRIG_4:         level = 7'd4;
         TRIG_8:         level = 7'd8;
         TRIG_NEAR_FULL: level = depth - 7'd2;
         default:        level = 7'd1;
      endcase
      return level;
   endfunction

   // Assemble the 32-bit rdr word from the head entry and the fill count.
   function automatic logic [31:0] pack_rdr(input logic valid,
                                            input logic [CNT_FIELD_W-1:0] cnt,
                                            input rx_entry_t entry);
      logic [31:0] word;
      word                             = 32'h0000_0000;
      word[VALID_BIT]                  = valid;
      word[CNT_LSB +: CNT_FIELD_W]     = cnt;
      word[ERR_LSB +: $bits(rx_err_t)] = entry.err;
      word[DATA_LSB +: DATA_W]         = entry.data;
      return word;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x W dual-port register array: synchronous write, asynchronous read,
// so synthesis maps it onto distributed RAM. Contents are not reset; the
// surrounding FIFO tracks validity with its own count.
// Ports:
//   clk    in  1   clock
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  W   write data
//   raddr  in  AW  read address
//   rdata  out W   read data (combinational)
// -----------------------------------------------------------------------------
module uart_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through receive buffer between the uart deserialiser and
// the rdr register. Holds characters with their error flags, presents the
// head as a registered 32-bit rdr word and produces trigger, timeout and
// sticky overrun status.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push_valid/data/err    character from the deserialiser (one-cycle pulse)
//   rx_read                rdr read, pops the head
//   sr_read                sr read, clears overrun_o
//   flush                  discard all entries
//   char_tick              one pulse per character time
//   trig_lvl               trigger level select (1, 4, 8, DEPTH-2)
//   rdr_o                  {16'h0, valid, cnt[3:0], err[2:0], data[7:0]}
//   count_o                entries held, 0..DEPTH
//   empty_o, full_o        fill status
//   trig_o                 count_o >= trigger level
//   timeout_o              non-empty and idle for TO_CHARS character times
//   overrun_o              sticky: a push was dropped while full
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int TO_CHARS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   input  logic [7:0]    push_data,
   input  logic [2:0]    push_err,
   input  logic          rx_read,
   input  logic          sr_read,
   input  logic          flush,
   input  logic          char_tick,
   input  logic [1:0]    trig_lvl,
   output logic [31:0]   rdr_o,
   output logic [AW:0]   count_o,
   output logic          empty_o,
   output logic          full_o,
   output logic          trig_o,
   output logic          timeout_o,
   output logic          overrun_o
);

   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [2:0]    to_cnt_q, to_cnt_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          trig_q, trig_d;
   logic          timeout_q, timeout_d;
   logic          overrun_q, overrun_d;
   logic [31:0]   rdr_q, rdr_d;

   logic          push_acc_s;
   logic          pop_s;
   logic          ovr_set_s;
   logic          bypass_s;
   rx_entry_t     push_entry_s;
   rx_entry_t     mem_rdata_s;
   rx_entry_t     head_s;

   // Storage. The read address is the next read pointer so that rdr_q can be
   // loaded with the new head at the same edge the pointers move.
   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (ENTRY_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_acc_s),
      .waddr (wr_ptr_q),
      .wdata (push_entry_s),
      .raddr (rd_ptr_d),
      .rdata (mem_rdata_s)
   );

   // Next-state logic for pointers, count, status flags and the rdr word.
   always_comb begin
      push_entry_s.err  = push_err;
      push_entry_s.data = push_data;

      // Flush overrides everything and silently discards a same-cycle push.
      // A push while full is still accepted when a pop frees a slot.
      push_acc_s = push_valid && (!full_q || rx_read) && !flush;
      pop_s      = rx_read && !empty_q && !flush;
      ovr_set_s  = push_valid && full_q && !rx_read && !flush;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = push_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
         rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
         case ({push_acc_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_CNT);

      if (ovr_set_s) begin
         overrun_d = 1'b1;
      end else if (sr_read) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      // Idle counter restarts on any FIFO activity and is held at zero while
      // empty; it saturates so a long idle period cannot wrap back below
      // the threshold.
      if (push_acc_s || pop_s || flush || empty_q) begin
         to_cnt_d = 3'd0;
      end else if (char_tick && (to_cnt_q != 3'd7)) begin
         to_cnt_d = to_cnt_q + 3'd1;
      end else begin
         to_cnt_d = to_cnt_q;
      end
      timeout_d = (to_cnt_d >= 3'(TO_CHARS)) && !empty_d;

      trig_d = (7'(count_d) >= trig_level(trig_lvl_e'(trig_lvl), 7'(DEPTH)));

      // The new head is the entry being written this cycle exactly when the
      // FIFO will hold a single entry that arrives now (push into empty, or
      // push+pop with one entry held); the RAM does not have it yet.
      bypass_s = push_acc_s && (count_d == CNT_ONE);
      if (bypass_s) begin
         head_s = push_entry_s;
      end else begin
         head_s = mem_rdata_s;
      end

      // Count field is 4 bits wide: zero-extended for small FIFOs,
      // low bits only when DEPTH needs more than 4 bits.
      if (empty_d) begin
         rdr_d = 32'h0000_0000;
      end else begin
         rdr_d = pack_rdr(1'b1, 4'(count_d), head_s);
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         to_cnt_q  <= 3'd0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         trig_q    <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         rdr_q     <= 32'h0000_0000;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         to_cnt_q  <= to_cnt_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         trig_q    <= trig_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
         rdr_q     <= rdr_d;
      end
   end

   assign rdr_o     = rdr_q;
   assign count_o   = count_q;
   assign empty_o   = empty_q;
   assign full_o    = full_q;
   assign trig_o    = trig_q;
   assign timeout_o = timeout_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo (DEPTH=16, TO_CHARS=4). Inputs change 1ns
// after the rising edge and outputs are sampled at that point too, so every
// check sees the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic [7:0]  push_data;
   logic [2:0]  push_err;
   logic        rx_read;
   logic        sr_read;
   logic        flush;
   logic        char_tick;
   logic [1:0]  trig_lvl;
   logic [31:0] rdr_o;
   logic [4:0]  count_o;
   logic        empty_o;
   logic        full_o;
   logic        trig_o;
   logic        timeout_o;
   logic        overrun_o;

   int checks = 0;
   int errors = 0;

   uart_rx_fifo #(.DEPTH(16), .AW(4), .TO_CHARS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_err   (push_err),
      .rx_read    (rx_read),
      .sr_read    (sr_read),
      .flush      (flush),
      .char_tick  (char_tick),
      .trig_lvl   (trig_lvl),
      .rdr_o      (rdr_o),
      .count_o    (count_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .trig_o     (trig_o),
      .timeout_o  (timeout_o),
      .overrun_o  (overrun_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] e);
      push_valid = 1'b1; push_data = d; push_err = e;
      cyc();
      push_valid = 1'b0; push_data = 8'h00; push_err = 3'b000;
   endtask

   task automatic pop();
      rx_read = 1'b1;
      cyc();
      rx_read = 1'b0;
   endtask

   task automatic tick();
      char_tick = 1'b1;
      cyc();
      char_tick = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
      checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      checks++; if (rdr_o !== 32'h0) begin errors++; $display("FAIL reset_rdr: got %h expected 00000000", rdr_o); end
      checks++; if ({full_o, trig_o, timeout_o, overrun_o} !== 4'b0000) begin errors++;
         $display("FAIL reset_status: got %b expected 0000", {full_o, trig_o, timeout_o, overrun_o}); end
   endtask

   task automatic test_basic();
      push(8'h41, 3'b000);
      checks++; if (rdr_o !== 32'h0000_8841) begin errors++; $display("FAIL basic_rdr1: got %h expected 00008841", rdr_o); end
      push(8'h42, 3'b000);
      checks++; if (rdr_o !== 32'h0000_9041) begin errors++; $display("FAIL basic_rdr2: got %h expected 00009041", rdr_o); end
      push(8'h43, 3'b000);
      checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL basic_count3: got %0d expected 3", count_o); end
      pop();
      checks++; if (rdr_o !== 32'h0000_9042) begin errors++; $display("FAIL basic_pop1: got %h expected 00009042", rdr_o); end
      checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL basic_count2: got %0d expected 2", count_o); end
      pop();
      checks++; if (rdr_o !== 32'h0000_8843) begin errors++; $display("FAIL basic_pop2: got %h expected 00008843", rdr_o); end
      pop();
      checks++; if ({count_o, empty_o, rdr_o} !== {5'd0, 1'b1, 32'h0}) begin errors++;
         $display("FAIL basic_drained: got count %0d empty %b rdr %h expected 0 1 00000000", count_o, empty_o, rdr_o); end
      pop();
      checks++; if ({count_o, empty_o} !== {5'd0, 1'b1}) begin errors++;
         $display("FAIL basic_pop_empty: got count %0d empty %b expected 0 1", count_o, empty_o); end
      push(8'h5A, 3'b101);
      checks++; if (rdr_o !== 32'h0000_8D5A) begin errors++; $display("FAIL basic_errflags: got %h expected 00008d5a", rdr_o); end
      pop();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) push(8'(i), 3'b000);
      checks++; if ({full_o, count_o, overrun_o} !== {1'b1, 5'd16, 1'b0}) begin errors++;
         $display("FAIL ovr_full: got full %b count %0d ovr %b expected 1 16 0", full_o, count_o, overrun_o); end
      checks++; if (rdr_o !== 32'h0000_8000) begin errors++; $display("FAIL ovr_rdr_full: got %h expected 00008000", rdr_o); end
      push(8'h10, 3'b000);
      checks++; if ({overrun_o, count_o} !== {1'b1, 5'd16}) begin errors++;
         $display("FAIL ovr_set: got ovr %b count %0d expected 1 16", overrun_o, count_o); end
      for (int i = 0; i < 16; i++) begin
         checks++; if ({rdr_o[15], rdr_o[7:0]} !== {1'b1, 8'(i)}) begin errors++;
            $display("FAIL ovr_read%0d: got valid %b data %h expected 1 %h", i, rdr_o[15], rdr_o[7:0], 8'(i)); end
         pop();
      end
      checks++; if ({empty_o, rdr_o} !== {1'b1, 32'h0}) begin errors++;
         $display("FAIL ovr_drained: got empty %b rdr %h expected 1 00000000", empty_o, rdr_o); end
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun_o); end
      sr_read = 1'b1; cyc(); sr_read = 1'b0;
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 3'b000);
      push_valid = 1'b1; push_data = 8'hAA; rx_read = 1'b1;
      cyc();
      push_valid = 1'b0; push_data = 8'h00; rx_read = 1'b0;
      checks++; if ({count_o, overrun_o, rdr_o[7:0]} !== {5'd16, 1'b0, 8'h21}) begin errors++;
         $display("FAIL fpp_state: got count %0d ovr %b head %h expected 16 0 21", count_o, overrun_o, rdr_o[7:0]); end
      for (int i = 0; i < 16; i++) begin
         logic [7:0] exp_d;
         exp_d = (i < 15) ? (8'h21 + 8'(i)) : 8'hAA;
         checks++; if (rdr_o[7:0] !== exp_d) begin errors++;
            $display("FAIL fpp_read%0d: got %h expected %h", i, rdr_o[7:0], exp_d); end
         pop();
      end
      checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %b expected 1", empty_o); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 3'b000);
      flush = 1'b1; push_valid = 1'b1; push_data = 8'h99;
      cyc();
      flush = 1'b0; push_valid = 1'b0; push_data = 8'h00;
      checks++; if ({count_o, empty_o, overrun_o, rdr_o} !== {5'd0, 1'b1, 1'b0, 32'h0}) begin errors++;
         $display("FAIL flush_state: got count %0d empty %b ovr %b rdr %h expected 0 1 0 00000000", count_o, empty_o, overrun_o, rdr_o); end
      for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), 3'b000);
      push_valid = 1'b1; push_data = 8'hEE; sr_read = 1'b1;
      cyc();
      push_valid = 1'b0; push_data = 8'h00; sr_read = 1'b0;
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL flush_ovr_vs_sr: got %b expected 1", overrun_o); end
      flush = 1'b1; cyc(); flush = 1'b0;
      checks++; if ({empty_o, overrun_o} !== 2'b11) begin errors++;
         $display("FAIL flush_keeps_ovr: got empty %b ovr %b expected 1 1", empty_o, overrun_o); end
      sr_read = 1'b1; cyc(); sr_read = 1'b0;
   endtask

   task automatic test_trigger();
      trig_lvl = 2'b01;
      for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 3'b000);
      checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL trig_3: got %b expected 0", trig_o); end
      push(8'h73, 3'b000);
      checks++; if (trig_o !== 1'b1) begin errors++; $display("FAIL trig_4: got %b expected 1", trig_o); end
      pop();
      checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL trig_pop: got %b expected 0", trig_o); end
      trig_lvl = 2'b00;
      cyc();
      checks++; if (trig_o !== 1'b1) begin errors++; $display("FAIL trig_lvl_change: got %b expected 1", trig_o); end
      for (int i = 0; i < 3; i++) pop();
      checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL trig_empty: got %b expected 0", trig_o); end
   endtask

   task automatic test_timeout();
      push(8'h55, 3'b000);
      for (int i = 0; i < 3; i++) tick();
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_3ticks: got %b expected 0", timeout_o); end
      tick();
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_4ticks: got %b expected 1", timeout_o); end
      pop();
      checks++; if ({timeout_o, empty_o} !== 2'b01) begin errors++;
         $display("FAIL to_pop: got timeout %b empty %b expected 0 1", timeout_o, empty_o); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_idle_empty: got %b expected 0", timeout_o); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) push(8'h80 + 8'(i), 3'b000);
      push_valid = 1'b1; push_data = 8'h85; rst = 1'b1;
      cyc();
      push_valid = 1'b0; push_data = 8'h00; rst = 1'b0;
      checks++; if ({count_o, empty_o, overrun_o, rdr_o} !== {5'd0, 1'b1, 1'b0, 32'h0}) begin errors++;
         $display("FAIL rstmid_state: got count %0d empty %b ovr %b rdr %h expected 0 1 0 00000000", count_o, empty_o, overrun_o, rdr_o); end
      push(8'h77, 3'b010);
      checks++; if ({count_o, rdr_o} !== {5'd1, 32'h0000_8A77}) begin errors++;
         $display("FAIL rstmid_push: got count %0d rdr %h expected 1 00008a77", count_o, rdr_o); end
      pop();
      checks++; if ({empty_o, rdr_o} !== {1'b1, 32'h0}) begin errors++;
         $display("FAIL rstmid_pop: got empty %b rdr %h expected 1 00000000", empty_o, rdr_o); end
   endtask

   initial begin
      rst = 1'b1; push_valid = 1'b0; push_data = 8'h00; push_err = 3'b000;
      rx_read = 1'b0; sr_read = 1'b0; flush = 1'b0; char_tick = 1'b0; trig_lvl = 2'b00;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      test_reset();
      test_basic();
      test_overrun();
      test_full_push_pop();
      test_flush();
      test_trigger();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
